nibble_seq_adder: RTL and testbench
===================================

Name: nibble_seq_adder

Overview:
Sequencing controller that performs a wide (4*NIBBLES-bit) addition by time-multiplexing the team's 4-bit ripple adder stage.
- It sits directly upstream and downstream of that stage: it feeds one operand nibble pair plus carry per cycle and consumes the nibble sum and carry-out.
- It assembles the full result and reports it with a single-cycle done pulse.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand/result width W = 4*NIBBLES; legal range 1..16.

Ports:
clk       input   1    single clock, all state updates on rising edge
rst       input   1    asynchronous, active-high reset
start     input   1    request; sampled only while idle (busy=0)
op_a      input   W    operand A, captured on accepted start
op_b      input   W    operand B, captured on accepted start
cin       input   1    carry-in, captured on accepted start
busy      output  1    high while an addition is in progress
done      output  1    one-cycle pulse: sum/cout valid and newly updated
sum       output  W    result, held until the next completion
cout      output  1    final carry-out, held until the next completion
add_a     output  4    nibble A driven to the 4-bit adder
add_b     output  4    nibble B driven to the 4-bit adder
add_cin   output  1    carry driven to the 4-bit adder
add_s     input   4    nibble sum returned by the 4-bit adder (combinational)
add_cout  input   1    carry-out returned by the 4-bit adder (combinational)

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, sum=0, cout=0; internal A/B/partial registers=0, idx=0, carry=0. Reset mid-operation aborts the addition and discards the partial result. No done pulse is issued.
- States: IDLE, RUN.
- IDLE:
  - busy=0.
  - add_a/add_b/add_cin driven to 0.
  - start=1 at an edge: latch op_a, op_b into a_reg, b_reg; carry<=cin; idx<=0; go to RUN.
- RUN:
  - busy=1.
  - add_a = a_reg[4*idx+3:4*idx], add_b = b_reg[same slice], add_cin = carry. These are combinational from registers only, with no dependency on start/op inputs.
  - Each edge: partial[4*idx+3:4*idx] <= add_s; carry <= add_cout; idx <= idx+1.
  - Edge where idx==NIBBLES-1: sum <= partial with the final nibble merged in; cout <= add_cout; done <= 1; go to IDLE; idx <= 0.
- done:
  - Registered; high exactly one cycle, which is the first IDLE cycle after completion; cleared on the next edge.
- Latency:
  - Accepted start at edge E0; nibbles captured at E1..E_NIBBLES.
  - done, updated sum/cout and busy=0 all become visible after edge E_NIBBLES (NIBBLES+1 edges after start is sampled).
  - Throughput: one result per NIBBLES+1 cycles.
- Back-to-back: start=1 during the done cycle is accepted (state is IDLE). The new operation does not disturb sum/cout until its own completion.
- start while busy=1 is ignored. op_a/op_b/cin changes during RUN have no effect.
- Arithmetic: {cout,sum} = op_a + op_b + cin, modulo 2^(W+1), exact. Carry ripples nibble to nibble through the carry register, LSB nibble first.
- sum and cout never show partial values; they change only on the completion edge or on reset.

Test Plan:
- NIBBLES=4; op_a=16'h1234, op_b=16'h4321, cin=0, start 1 cycle -> busy high 4 cycles; add_a sequence 4,3,2,1; done after 5th edge with sum=16'h5555, cout=0.
- op_a=16'hFFFF, op_b=16'h0001, cin=0 -> add_cin sequence 0,1,1,1; sum=16'h0000, cout=1. Then op_a=16'hFFFF, op_b=16'hFFFF, cin=1 -> sum=16'hFFFF, cout=1.
- Second start pulsed while busy=1 with different operands -> ignored; first result (16'h5555) completes unchanged. Start asserted in the done cycle -> accepted; next done 5 edges later with the new result.
- rst asserted asynchronously after 2 RUN edges (mid-cycle, between clock edges) -> busy, done, sum, cout go 0 immediately without an edge. No done pulse follows. Fresh start afterwards gives a correct result.
- Paired with a behavioural 4-bit adder model, 200 random op_a/op_b/cin sets -> each {cout,sum} equals the reference sum; done high exactly one cycle per accepted start.
- NIBBLES=1 build; op_a=4'h9, op_b=4'h8, cin=1 -> done after 2nd edge, sum=4'h2, cout=1.

Source files
------------

// File: rtl/nibble_seq_adder_if.sv
// Bundle of request/result and 4-bit adder stage signals for nibble_seq_adder.
// The slave side is the sequencer; the master side is the requester plus the
// external 4-bit ripple adder stage that answers add_a/add_b/add_cin.
interface nibble_seq_adder_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_s;
  logic         add_cout;

  modport slave (
    input  start, op_a, op_b, cin, add_s, add_cout,
    output busy, done, sum, cout, add_a, add_b, add_cin
  );

  modport master (
    output start, op_a, op_b, cin, add_s, add_cout,
    input  busy, done, sum, cout, add_a, add_b, add_cin
  );
endinterface

// File: rtl/nibble_seq_adder.sv
// Wide adder built by time-multiplexing an external 4-bit ripple adder stage.
// One nibble pair is processed per cycle, LSB nibble first, with the carry
// held in a register between slices. The assembled result is published in
// one step together with a single-cycle done pulse.
module nibble_seq_adder #(
  parameter int NIBBLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  nibble_seq_adder_if.slave bus
);
  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = $clog2(NIBBLES + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

  logic [0:0]      state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    part_q, part_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            done_q, done_d;

  // Partial result with the nibble coming back from the adder merged in;
  // on the last slice this is the complete sum.
  logic [W-1:0]    part_merged;

  // Adder stage operands: driven only from registers, zero while idle.
  always_comb begin
    bus.add_a   = 4'h0;
    bus.add_b   = 4'h0;
    bus.add_cin = 1'b0;
    if (state_q == RUN) begin
      bus.add_a   = a_q[4*idx_q +: 4];
      bus.add_b   = b_q[4*idx_q +: 4];
      bus.add_cin = carry_q;
    end
  end

  // Next-state logic: accept a request while idle, walk the slices while running.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    part_d      = part_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    done_d      = 1'b0;
    part_merged = part_q;
    part_merged[4*idx_q +: 4] = bus.add_s;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.op_a;
          b_d     = bus.op_b;
          carry_d = bus.cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        part_d  = part_merged;
        carry_d = bus.add_cout;
        if (idx_q == LAST) begin
          // sum/cout only ever change here, so no partial value is visible
          sum_d   = part_merged;
          cout_d  = bus.add_cout;
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any addition in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_nibble_seq_adder.sv
// Bench for nibble_seq_adder: behavioural 4-bit adder stage, directed and
// random additions, scoreboard queue of expected {cout,sum} drained by a
// monitor on done, plus a NIBBLES=1 build.
module tb_nibble_seq_adder;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nibble_seq_adder_if #(.NIBBLES(N)) bus ();
  nibble_seq_adder_if #(.NIBBLES(1)) bus1 ();

  nibble_seq_adder #(.NIBBLES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  nibble_seq_adder #(.NIBBLES(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  // Behavioural 4-bit adder stages
  assign {bus.add_cout, bus.add_s}   = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'b0, bus.add_cin};
  assign {bus1.add_cout, bus1.add_s} = {1'b0, bus1.add_a} + {1'b0, bus1.add_b} + {4'b0, bus1.add_cin};

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int dones = 0;
  int txn = 0;
  bit done_prev = 1'b0;
  logic [W:0] exp_q[$];
  logic [W:0] last_res = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Carry into nibble k of a+b+c, computed from whole-number arithmetic
  function automatic logic carry_into(input logic [63:0] a, input logic [63:0] b,
                                      input logic c, input int k);
    logic [63:0] mask;
    logic [63:0] s;
    mask = (64'd1 << (4 * k)) - 64'd1;
    s = (a & mask) + (b & mask) + {63'd0, c};
    return s[4*k];
  endfunction

  // Monitor: pops an expectation whenever the DUT reports done
  always @(negedge clk) begin
    if (bus.done) begin
      dones++;
      check("done_width", {63'd0, done_prev}, 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got sum=%h cout=%b required no done", bus.sum, bus.cout);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("result", {47'd0, bus.cout, bus.sum}, {47'd0, e});
        txn++;
        $display("txn %0d: sum=%h cout=%b expected sum=%h cout=%b",
                 txn, bus.sum, bus.cout, e[W-1:0], e[W]);
      end
    end
    done_prev = bus.done;
  end

  // One addition; called #1 after an edge with the DUT idle
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input bit inject);
    logic [W:0] e;
    check("idle_before_start", {63'd0, bus.busy}, 64'd0);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = c;
    e = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    exp_q.push_back(e);
    accepted++;
    step();
    for (int k = 0; k < N; k++) begin
      check("busy_run", {63'd0, bus.busy}, 64'd1);
      check("add_a", {60'd0, bus.add_a}, {60'd0, 4'((a >> (4 * k)) & 16'hF)});
      check("add_b", {60'd0, bus.add_b}, {60'd0, 4'((b >> (4 * k)) & 16'hF)});
      check("add_cin", {63'd0, bus.add_cin}, {63'd0, carry_into({48'd0, a}, {48'd0, b}, c, k)});
      check("hold_result", {47'd0, bus.cout, bus.sum}, {47'd0, last_res});
      // inputs wander during RUN; a second start mid-run must be ignored
      bus.op_a  = W'($urandom);
      bus.op_b  = W'($urandom);
      bus.cin   = 1'($urandom);
      bus.start = inject && (k == 1);
      step();
    end
    bus.start = 1'b0;
    check("busy_end", {63'd0, bus.busy}, 64'd0);
    check("done_end", {63'd0, bus.done}, 64'd1);
    last_res = e;
  endtask

  initial begin
    logic [W:0] dummy;
    bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.cin = 1'b0;
    bus1.start = 1'b0; bus1.op_a = '0; bus1.op_b = '0; bus1.cin = 1'b0;

    #3;
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_sum", {48'd0, bus.sum}, 64'd0);
    check("rst_cout", {63'd0, bus.cout}, 64'd0);
    check("rst_add_a", {60'd0, bus.add_a}, 64'd0);
    step();
    rst = 1'b0;
    step();

    // Directed cases
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    run_op(16'h1234, 16'h4321, 1'b0, 1'b1);   // busy start ignored, back-to-back
    run_op(16'h0F0F, 16'hF0F1, 1'b1, 1'b0);   // back-to-back from done cycle

    // Asynchronous reset after two RUN edges
    bus.start = 1'b1;
    bus.op_a  = 16'hABCD;
    bus.op_b  = 16'h1111;
    bus.cin   = 1'b0;
    step();
    bus.start = 1'b0;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", {63'd0, bus.busy}, 64'd0);
    check("arst_done", {63'd0, bus.done}, 64'd0);
    check("arst_sum", {48'd0, bus.sum}, 64'd0);
    check("arst_cout", {63'd0, bus.cout}, 64'd0);
    last_res = '0;
    step();
    rst = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      step();
      check("no_done_after_rst", {63'd0, bus.done}, 64'd0);
    end
    run_op(16'h8000, 16'h8000, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) step();
      end
    end

    // NIBBLES=1 build
    bus1.start = 1'b1;
    bus1.op_a  = 4'h9;
    bus1.op_b  = 4'h8;
    bus1.cin   = 1'b1;
    step();
    bus1.start = 1'b0;
    check("n1_busy", {63'd0, bus1.busy}, 64'd1);
    check("n1_add_a", {60'd0, bus1.add_a}, 64'h9);
    check("n1_add_cin", {63'd0, bus1.add_cin}, 64'd1);
    step();
    check("n1_done", {63'd0, bus1.done}, 64'd1);
    check("n1_busy_end", {63'd0, bus1.busy}, 64'd0);
    check("n1_result", {59'd0, bus1.cout, bus1.sum}, {59'd0, 1'b1, 4'h2});
    step();
    check("n1_done_clear", {63'd0, bus1.done}, 64'd0);

    // Drain and reconcile
    repeat (3) step();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("done_count", 64'(dones), 64'(accepted));
    dummy = '0;
    if (dummy != 0) exp_q.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Reset mid-run discards the pending expectation
  always @(posedge rst) begin
    if (exp_q.size() != 0) begin
      exp_q.delete();
      accepted--;
    end
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL timeout: got no finish required finish within limit");
    $fatal(1, "timeout");
  end

endmodule
